// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the register file's single write port between NUM_REQ writeback
// sources (ALU, load data, mul/div, ...). A round-robin arbiter picks one
// valid requester per cycle and answers with a one-hot, combinational
// ReqReady. The accepted write is presented on registered write-port outputs
// one cycle later.
//
// Optional build macro: SCOREBOARD_EN
//   When defined, a per-register busy-bit scoreboard is added. It uses the
//   IssueValid_i/IssueReg_i inputs and the Busy_o output. Without the macro
//   those ports do not exist and no scoreboard state is built.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,   // number of writeback requesters (2..8)
  parameter int DATA_W  = 32,  // write data width
  parameter int ADDR_W  = 5,   // register index width
  parameter int CNT_W   = 16   // contention counter width
) (
  input  logic                      Clock_i,
  input  logic                      Reset_L_i,
  input  logic [NUM_REQ-1:0]        ReqValid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] ReqReg_i,
  input  logic [NUM_REQ*DATA_W-1:0] ReqData_i,
  output logic [NUM_REQ-1:0]        ReqReady_o,
  output logic                      RegWrite_o,
  output logic [ADDR_W-1:0]         WriteReg_o,
  output logic [DATA_W-1:0]         WriteData_o,
  output logic [NUM_REQ-1:0]        LastGrant_o,
  output logic [CNT_W-1:0]          ConflictCnt_o
`ifdef SCOREBOARD_EN
  ,
  input  logic                      IssueValid_i,
  input  logic [ADDR_W-1:0]         IssueReg_i,
  output logic [(2**ADDR_W)-1:0]    Busy_o
`endif
);

  // Pointer width. One extra bit is used for the modulo add, so that
  // ptr + offset (which is < 2*NUM_REQ) never overflows.
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Per-requester views of the flattened request buses.
  logic [ADDR_W-1:0] req_reg  [NUM_REQ];
  logic [DATA_W-1:0] req_data [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_reg[gi]  = ReqReg_i[gi*ADDR_W +: ADDR_W];
      assign req_data[gi] = ReqData_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // State registers
  logic [PTR_W-1:0]   ptr_q,          ptr_d;
  logic               reg_write_q,    reg_write_d;
  logic [ADDR_W-1:0]  write_reg_q,    write_reg_d;
  logic [DATA_W-1:0]  write_data_q,   write_data_d;
  logic [NUM_REQ-1:0] last_grant_q,   last_grant_d;
  logic [CNT_W-1:0]   conflict_cnt_q, conflict_cnt_d;

  // Arbitration results
  logic [SUM_W-1:0]   sum;
  logic [PTR_W-1:0]   cand;
  logic               found;
  logic [PTR_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] grant;
  logic               transfer;
  logic [ADDR_W-1:0]  sel_reg;
  logic [DATA_W-1:0]  sel_data;
  logic               multi_valid;

  // Round-robin search. Start at ptr_q, wrap modulo NUM_REQ, and take the
  // first valid requester found.
  always_comb begin
    sum     = '0;
    cand    = '0;
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + SUM_W'(k);
      if (sum >= SUM_W'(NUM_REQ)) begin
        sum = sum - SUM_W'(NUM_REQ);
      end
      cand = sum[PTR_W-1:0];
      if (!found && ReqValid_i[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  // One-hot grant. Held at zero while reset is asserted, so nothing is
  // accepted during reset.
  always_comb begin
    grant = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      grant[j] = found && Reset_L_i && (win_idx == PTR_W'(j));
    end
  end

  assign ReqReady_o = grant;
  assign transfer   = |grant;
  assign sel_reg    = req_reg[win_idx];
  assign sel_data   = req_data[win_idx];

  // More than one requester is valid when clearing the lowest set bit still
  // leaves a bit set.
  assign multi_valid = |(ReqValid_i & (ReqValid_i - NUM_REQ'(1)));

  // Next-state for the pointer, the write port and the contention counter.
  // A write to register 0 is still accepted, but it never raises RegWrite.
  always_comb begin
    ptr_d          = ptr_q;
    reg_write_d    = 1'b0;
    write_reg_d    = write_reg_q;
    write_data_d   = write_data_q;
    last_grant_d   = last_grant_q;
    conflict_cnt_d = conflict_cnt_q;
    if (transfer) begin
      ptr_d        = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
      reg_write_d  = (sel_reg != '0);
      write_reg_d  = sel_reg;
      write_data_d = sel_data;
      last_grant_d = grant;
    end
    if (multi_valid && (conflict_cnt_q != CNT_MAX)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end
  end

  // Arbiter and write-port registers. An asynchronous reset drops any
  // pending write immediately.
  always_ff @(posedge Clock_i or negedge Reset_L_i) begin
    if (!Reset_L_i) begin
      ptr_q          <= '0;
      reg_write_q    <= 1'b0;
      write_reg_q    <= '0;
      write_data_q   <= '0;
      last_grant_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      ptr_q          <= ptr_d;
      reg_write_q    <= reg_write_d;
      write_reg_q    <= write_reg_d;
      write_data_q   <= write_data_d;
      last_grant_q   <= last_grant_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign RegWrite_o    = reg_write_q;
  assign WriteReg_o    = write_reg_q;
  assign WriteData_o   = write_data_q;
  assign LastGrant_o   = last_grant_q;
  assign ConflictCnt_o = conflict_cnt_q;

`ifdef SCOREBOARD_EN
  localparam int NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // The write clears the busy bit first, then a new issue sets it. The set
  // is applied last so that it wins: the new reservation is the younger one.
  // $zero never becomes busy.
  always_comb begin
    busy_d = busy_q;
    if (reg_write_d) begin
      busy_d[sel_reg] = 1'b0;
    end
    if (IssueValid_i) begin
      busy_d[IssueReg_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy-bit register
  always_ff @(posedge Clock_i or negedge Reset_L_i) begin
    if (!Reset_L_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign Busy_o = busy_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter (NUM_REQ=3, CNT_W=4 so that
// counter saturation can be reached quickly). Table-driven vectors with a
// scoreboard of expected write-port results, plus hand-written sequences
// for the asynchronous reset and, with SCOREBOARD_EN, the busy bits.
module tb_regfile_write_arbiter;
  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int CNT_W   = 4;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_reg;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      reg_write;
  logic [ADDR_W-1:0]         write_reg;
  logic [DATA_W-1:0]         write_data;
  logic [NUM_REQ-1:0]        last_grant;
  logic [CNT_W-1:0]          conflict_cnt;
`ifdef SCOREBOARD_EN
  logic                      issue_valid;
  logic [ADDR_W-1:0]         issue_reg;
  logic [(2**ADDR_W)-1:0]    busy;
`endif

  regfile_write_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .Clock_i      (clk),
    .Reset_L_i    (rst_n),
    .ReqValid_i   (req_valid),
    .ReqReg_i     (req_reg),
    .ReqData_i    (req_data),
    .ReqReady_o   (req_ready),
    .RegWrite_o   (reg_write),
    .WriteReg_o   (write_reg),
    .WriteData_o  (write_data),
    .LastGrant_o  (last_grant),
    .ConflictCnt_o(conflict_cnt)
`ifdef SCOREBOARD_EN
    ,
    .IssueValid_i (issue_valid),
    .IssueReg_i   (issue_reg),
    .Busy_o       (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_REQ-1:0]        valid;
    logic [NUM_REQ*ADDR_W-1:0] regs;
    logic [NUM_REQ*DATA_W-1:0] data;
    logic [NUM_REQ-1:0]        exp_ready;
  } vec_t;

  typedef struct {
    logic               rw;
    logic [ADDR_W-1:0]  wr;
    logic [DATA_W-1:0]  wd;
    logic [NUM_REQ-1:0] lg;
    logic [CNT_W-1:0]   cnt;
  } exp_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];
  exp_t exp_q [$];

  int checks = 0;
  int errors = 0;

  // Expected write-port state, used to model the "hold" behaviour.
  logic [ADDR_W-1:0]  m_wr  = '0;
  logic [DATA_W-1:0]  m_wd  = '0;
  logic [NUM_REQ-1:0] m_lg  = '0;
  logic [CNT_W-1:0]   m_cnt = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_vec(input int i, input logic [NUM_REQ-1:0] v, input logic [NUM_REQ-1:0] r);
    vecs[i].valid     = v;
    vecs[i].exp_ready = r;
    for (int j = 0; j < NUM_REQ; j++) begin
      vecs[i].regs[j*ADDR_W +: ADDR_W] = ADDR_W'(((i * 3 + j) % 31) + 1);
      vecs[i].data[j*DATA_W +: DATA_W] = 32'hA000_0000 | DATA_W'(i << 8) | DATA_W'(j);
    end
  endtask

  initial begin
    exp_t e;
    int   w;

    // The pointer starts at 0 after reset. Each expected grant below is
    // derived by hand from the round-robin rule.
    set_vec(0,  3'b111, 3'b001);
    set_vec(1,  3'b111, 3'b010);
    set_vec(2,  3'b111, 3'b100);
    set_vec(3,  3'b111, 3'b001);
    set_vec(4,  3'b111, 3'b010);
    set_vec(5,  3'b111, 3'b100);   // ptr=0, conflicts=6
    set_vec(6,  3'b010, 3'b010);   // single source -> ptr=2
    vecs[6].regs[1*ADDR_W +: ADDR_W] = 5'd8;
    vecs[6].data[1*DATA_W +: DATA_W] = 32'h0000_0004;
    set_vec(7,  3'b001, 3'b001);   // register 0 -> ptr=1
    vecs[7].regs[0 +: ADDR_W] = 5'd0;
    vecs[7].data[0 +: DATA_W] = 32'h0000_0005;
    set_vec(8,  3'b000, 3'b000);
    set_vec(9,  3'b101, 3'b100);   // ptr=1 -> 2 wins, ptr=0
    set_vec(10, 3'b101, 3'b001);   // ptr=1
    set_vec(11, 3'b011, 3'b010);   // ptr=2
    set_vec(12, 3'b011, 3'b001);   // wrap to 0, ptr=1, conflicts=10
    set_vec(13, 3'b111, 3'b010);
    set_vec(14, 3'b111, 3'b100);
    set_vec(15, 3'b111, 3'b001);
    set_vec(16, 3'b111, 3'b010);
    set_vec(17, 3'b111, 3'b100);   // counter reaches 15
    set_vec(18, 3'b111, 3'b001);   // saturated, ptr=1
    set_vec(19, 3'b000, 3'b000);

    // Reset with all requesters valid
    rst_n     = 1'b0;
    req_valid = 3'b111;
    req_reg   = '0;
    req_data  = '0;
`ifdef SCOREBOARD_EN
    issue_valid = 1'b0;
    issue_reg   = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", req_ready, 3'b000);
    chk("reset_regwrite", reg_write, 1'b0);
    chk("reset_writereg", write_reg, 5'd0);
    chk("reset_writedata", write_data, 32'd0);
    chk("reset_lastgrant", last_grant, 3'b000);
    chk("reset_conflict", conflict_cnt, 4'd0);
`ifdef SCOREBOARD_EN
    chk("reset_busy", busy, 32'd0);
`endif
    req_valid = '0;
    rst_n     = 1'b1;

    // Table-driven run with a scoreboard
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      req_valid = vecs[i].valid;
      req_reg   = vecs[i].regs;
      req_data  = vecs[i].data;
      #1;
      chk($sformatf("v%0d_ready", i), req_ready, vecs[i].exp_ready);
      if (vecs[i].exp_ready != '0) begin
        w = 0;
        for (int j = 0; j < NUM_REQ; j++) if (vecs[i].exp_ready[j]) w = j;
        m_wr = vecs[i].regs[w*ADDR_W +: ADDR_W];
        m_wd = vecs[i].data[w*DATA_W +: DATA_W];
        m_lg = vecs[i].exp_ready;
        e.rw = (m_wr != '0);
      end else begin
        e.rw = 1'b0;
      end
      if ($countones(vecs[i].valid) >= 2 && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
      e.wr = m_wr; e.wd = m_wd; e.lg = m_lg; e.cnt = m_cnt;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d_regwrite", i), reg_write, e.rw);
      chk($sformatf("v%0d_writereg", i), write_reg, e.wr);
      chk($sformatf("v%0d_writedata", i), write_data, e.wd);
      chk($sformatf("v%0d_lastgrant", i), last_grant, e.lg);
      chk($sformatf("v%0d_conflict", i), conflict_cnt, e.cnt);
    end
    chk("queue_drained", 128'(exp_q.size()), 128'd0);

    // Reset asserted between an accept and the following edge (ptr=1 here)
    @(negedge clk);
    req_valid = 3'b010;
    req_reg   = {5'd0, 5'd8, 5'd0};
    req_data  = {32'd0, 32'h0000_0004, 32'd0};
    #1;
    chk("midrst_accept_ready", req_ready, 3'b010);
    @(posedge clk);
    #1;
    chk("midrst_regwrite_before", reg_write, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_regwrite", reg_write, 1'b0);
    chk("midrst_lastgrant", last_grant, 3'b000);
    chk("midrst_writereg", write_reg, 5'd0);
    chk("midrst_conflict", conflict_cnt, 4'd0);
    chk("midrst_ready", req_ready, 3'b000);
    @(negedge clk);
    req_valid = 3'b111;
    req_reg   = {5'd3, 5'd2, 5'd1};
    req_data  = {32'h33, 32'h22, 32'h11};
    rst_n     = 1'b1;
    #1;
    chk("postrst_ready_ptr0", req_ready, 3'b001);
    @(posedge clk);
    #1;
    chk("postrst_lastgrant", last_grant, 3'b001);
    chk("postrst_writereg", write_reg, 5'd1);
    chk("postrst_writedata", write_data, 32'h11);
    chk("postrst_conflict", conflict_cnt, 4'd1);
    @(negedge clk);
    req_valid = '0;

`ifdef SCOREBOARD_EN
    // Busy-bit scoreboard (ptr=1 at this point)
    issue_valid = 1'b1;
    issue_reg   = 5'd9;
    @(posedge clk);
    #1;
    chk("sb_issue9", busy[9], 1'b1);
    @(negedge clk);
    issue_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("sb_hold9", busy[9], 1'b1);
    @(negedge clk);
    req_valid   = 3'b001;
    req_reg     = {5'd0, 5'd0, 5'd9};
    req_data    = {32'd0, 32'd0, 32'h99};
    issue_valid = 1'b1;
    issue_reg   = 5'd9;
    #1;
    chk("sb_write_ready", req_ready, 3'b001);
    @(posedge clk);
    #1;
    chk("sb_setwins9", busy[9], 1'b1);
    chk("sb_write_regwrite", reg_write, 1'b1);
    @(negedge clk);
    issue_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("sb_clear9", busy[9], 1'b0);
    @(negedge clk);
    req_valid   = '0;
    issue_valid = 1'b1;
    issue_reg   = 5'd0;
    @(posedge clk);
    #1;
    chk("sb_reg0", busy[0], 1'b0);
    chk("sb_all_clear", busy, 32'd0);
    @(negedge clk);
    issue_valid = 1'b0;
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
